// File: rtl/seq_det_pkg.sv
// Shared types, default widths and helpers for the serial pattern-detection
// frame controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    if (value >= max_value) begin
      return max_value;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/seq_pattern_moore.sv
// Programmable Moore pattern detector: keeps the last PAT_W bits seen, a
// saturating fill counter so partial histories never match, and a pattern
// register. match_pulse is registered, one cycle after the completing bit.
module seq_pattern_moore
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_load,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             match_pulse
);

  localparam int          FILL_W   = $clog2(PAT_W + 1);
  localparam logic [31:0] FILL_MAX = 32'(PAT_W);

  logic [PAT_W-1:0]  pattern_reg;
  logic [PAT_W-1:0]  hist_reg;
  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic              match_reg;

  // History as it will look once the current bit is included.
  always_comb begin
    hist_next = {hist_reg[PAT_W-2:0], bit_in};
    fill_next = FILL_W'(sat_inc(32'(fill_reg), FILL_MAX));
  end

  // Pattern register, bit history, fill level and the registered match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_reg <= '0;
      hist_reg    <= '0;
      fill_reg    <= '0;
      match_reg   <= 1'b0;
    end else begin
      if (cfg_load) begin
        pattern_reg <= cfg_pattern;
      end
      if (clear) begin
        hist_reg  <= '0;
        fill_reg  <= '0;
        match_reg <= 1'b0;
      end else if (bit_valid) begin
        hist_reg  <= hist_next;
        fill_reg  <= fill_next;
        match_reg <= (32'(fill_next) == FILL_MAX) && (hist_next == pattern_reg);
      end else begin
        match_reg <= 1'b0;
      end
    end
  end

  assign match_pulse = match_reg;

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Frame controller: accepts words over valid/ready, serialises them MSB-first
// into the pattern detector, counts matches per frame and reports the
// saturated count for one cycle after the last word has been flushed.
module seq_det_stream_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              count_valid,
  output logic              busy
);

  localparam int               IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);
  localparam logic [31:0]      CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic              last_reg;
  logic              live_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  match_count_reg;
  logic              count_valid_reg;

  logic word_done;
  logic accept;
  logic cfg_take;
  logic det_clear;

  // Handshake, config acceptance and next match count.
  // live_reg holds in_ready low while reset is asserted.
  always_comb begin
    word_done = (state_reg == SHIFT) && (bit_idx_reg == '0);
    in_ready  = live_reg && ((state_reg == IDLE) || (word_done && !last_reg));
    accept    = in_valid && in_ready;
    // A word arriving together with cfg_load takes priority.
    cfg_take  = (state_reg == IDLE) && cfg_load && !accept;
    det_clear = cfg_take || (state_reg == REPORT);
    cnt_next  = match_pulse ? CNT_W'(sat_inc(32'(cnt_reg), CNT_MAX)) : cnt_reg;
  end

  // Frame FSM, shift register, match counter and report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      bit_idx_reg     <= '0;
      last_reg        <= 1'b0;
      live_reg        <= 1'b0;
      cnt_reg         <= '0;
      match_count_reg <= '0;
      count_valid_reg <= 1'b0;
    end else begin
      live_reg        <= 1'b1;
      cnt_reg         <= cnt_next;
      count_valid_reg <= 1'b0;
      match_count_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shreg_reg   <= in_data;
            last_reg    <= in_last;
            bit_idx_reg <= IDX_TOP;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!word_done) begin
            shreg_reg   <= {shreg_reg[DATA_W-2:0], 1'b0};
            bit_idx_reg <= bit_idx_reg - 1'b1;
          end else if (last_reg) begin
            state_reg <= FLUSH;
          end else if (accept) begin
            // Gapless reload for the next word of the same frame.
            shreg_reg   <= in_data;
            last_reg    <= in_last;
            bit_idx_reg <= IDX_TOP;
          end else begin
            state_reg <= IDLE;
          end
        end
        FLUSH: begin
          // cnt_next already includes a match on the final bit.
          state_reg       <= REPORT;
          count_valid_reg <= 1'b1;
          match_count_reg <= cnt_next;
        end
        REPORT: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bit_valid   = (state_reg == SHIFT);
  assign bit_out     = bit_valid & shreg_reg[DATA_W-1];
  assign busy        = (state_reg != IDLE);
  assign match_count = match_count_reg;
  assign count_valid = count_valid_reg;

  seq_pattern_moore #(
    .PAT_W(PAT_W)
  ) u_detector (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_pattern(cfg_pattern),
    .cfg_load   (cfg_take),
    .clear      (det_clear),
    .bit_in     (bit_out),
    .bit_valid  (bit_valid),
    .match_pulse(match_pulse)
  );

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Bench for seq_det_stream_ctrl: directed scenarios plus random frames checked
// against a bit-stream window-counting model. A second instance with CNT_W=2
// shares all inputs to exercise counter saturation.
module tb_seq_det_stream_ctrl;

  localparam int DATA_W  = 8;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_W_S = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t word_q_t[$];

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PAT_W-1:0]   cfg_pattern = '0;
  logic               cfg_load = 1'b0;
  logic               in_valid = 1'b0;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_last = 1'b0;

  logic               in_ready, bit_out, bit_valid, match_pulse, count_valid, busy;
  logic [CNT_W-1:0]   match_count;
  logic               in_ready_s, bit_out_s, bit_valid_s, match_pulse_s, count_valid_s, busy_s;
  logic [CNT_W_S-1:0] match_count_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int mp_cnt = 0;
  int bv_cnt = 0;
  int cv_cnt = 0;
  bit seen_bits[$];
  logic [PAT_W-1:0] model_pat = '0;

  seq_det_stream_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_pattern(cfg_pattern), .cfg_load(cfg_load),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .match_pulse(match_pulse),
    .match_count(match_count), .count_valid(count_valid), .busy(busy)
  );

  seq_det_stream_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W_S)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_pattern(cfg_pattern), .cfg_load(cfg_load),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready_s),
    .bit_out(bit_out_s), .bit_valid(bit_valid_s), .match_pulse(match_pulse_s),
    .match_count(match_count_s), .count_valid(count_valid_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe serial activity away from the active edge.
  always @(negedge clk) begin
    if (match_pulse) mp_cnt++;
    if (bit_valid) begin
      bv_cnt++;
      seen_bits.push_back(bit_out);
    end
    if (count_valid) cv_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: count every PAT_W-bit window of the frame's MSB-first bit stream.
  function automatic int model_matches(input word_q_t words, input logic [PAT_W-1:0] pat);
    bit stream[$];
    int hits;
    int v;
    hits = 0;
    foreach (words[w]) begin
      for (int b = DATA_W - 1; b >= 0; b--) stream.push_back(words[w][b]);
    end
    for (int i = PAT_W - 1; i < stream.size(); i++) begin
      v = 0;
      for (int k = 0; k < PAT_W; k++) v = v * 2 + int'(stream[i - PAT_W + 1 + k]);
      if (v == int'(pat)) hits++;
    end
    return hits;
  endfunction

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern(input logic [PAT_W-1:0] p);
    cfg_pattern = p;
    cfg_load    = 1'b1;
    step();
    cfg_load    = 1'b0;
    cfg_pattern = PAT_W'($urandom);
    model_pat   = p;
  endtask

  task automatic send_word(input word_t data, input bit last, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin
        step();
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    in_last  = 1'($urandom);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: word %h not accepted within 100 cycles", data);
    end
  endtask

  // Leaves the bench in the REPORT cycle; lat is the cycle index counted from
  // the last accept edge (cycle 1 = first bit of the last word).
  task automatic wait_report(output int cnt, output int cnt_s, output int lat);
    bit ok;
    ok = 1'b0;
    cnt = -1;
    cnt_s = -1;
    lat = 0;
    for (int t = 1; t <= 40; t++) begin
      if (count_valid) begin
        ok = 1'b1;
        lat = t;
        cnt = int'(match_count);
        cnt_s = int'(match_count_s);
        break;
      end
      step();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL report_timeout: no count_valid within 40 cycles");
    end
  endtask

  task automatic run_frame(input word_q_t words, input int max_gap,
                           output int cnt, output int cnt_s, output int lat);
    int acc;
    mp_cnt = 0;
    bv_cnt = 0;
    cv_cnt = 0;
    seen_bits.delete();
    foreach (words[i]) begin
      if (i > 0) repeat ($urandom_range(max_gap, 0)) step();
      send_word(words[i], (i == words.size() - 1), acc);
    end
    wait_report(cnt, cnt_s, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, bit_out, bit_valid, match_pulse, count_valid, busy, match_count,
         in_ready_s, bit_out_s, bit_valid_s, match_pulse_s, count_valid_s, busy_s,
         match_count_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b busy=%b cv=%b cnt=%0d required all zero",
               in_ready, busy, count_valid, match_count);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b busy=%b required ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_single_word();
    word_q_t w;
    int cnt, cnt_s, lat;
    load_pattern(4'b1011);
    w = '{8'hB0};
    run_frame(w, 0, cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 1 || lat !== DATA_W + 2) begin
      n_fail++;
      $display("FAIL single_b0: got count=%0d cycle=%0d required count=1 cycle=%0d", cnt, lat, DATA_W + 2);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_report: got in_ready=%b required 0", in_ready);
    end
    step();
    n_checks++;
    if (count_valid !== 1'b0 || in_ready !== 1'b1 || mp_cnt !== 1) begin
      n_fail++;
      $display("FAIL after_report: got cv=%b ready=%b pulses=%0d required cv=0 ready=1 pulses=1",
               count_valid, in_ready, mp_cnt);
    end
  endtask

  task automatic test_overlap();
    word_q_t w;
    int cnt, cnt_s, lat;
    w = '{8'h5B};
    run_frame(w, 0, cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 2 || cnt_s !== 2) begin
      n_fail++;
      $display("FAIL overlap_5b: got count=%0d sat_count=%0d required 2/2", cnt, cnt_s);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int c1, c2, cnt, cnt_s, lat;
    mp_cnt = 0;
    bv_cnt = 0;
    send_word(8'h01, 1'b0, c1);
    send_word(8'h60, 1'b1, c2);
    wait_report(cnt, cnt_s, lat);
    n_checks++;
    if (c2 - c1 !== DATA_W) begin
      n_fail++;
      $display("FAIL b2b_gap: got accept spacing=%0d required %0d", c2 - c1, DATA_W);
    end
    n_checks++;
    if (cnt !== 1 || bv_cnt !== 2 * DATA_W) begin
      n_fail++;
      $display("FAIL b2b_cross: got count=%0d bit_valid cycles=%0d required 1/%0d", cnt, bv_cnt, 2 * DATA_W);
    end
    step();
  endtask

  task automatic test_frame_boundary();
    word_q_t w;
    int cnt, cnt_s, lat;
    w = '{8'h01};
    run_frame(w, 0, cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL frame1_01: got count=%0d required 0", cnt);
    end
    step();
    w = '{8'h60};
    run_frame(w, 0, cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL frame2_60: got count=%0d required 0 (history must not span frames)", cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    word_q_t w;
    int cnt, cnt_s, lat;
    load_pattern(4'b0000);
    w = '{8'h00};
    run_frame(w, 0, cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 5 || cnt_s !== 3 || mp_cnt !== 5) begin
      n_fail++;
      $display("FAIL saturate: got count=%0d sat_count=%0d pulses=%0d required 5/3/5", cnt, cnt_s, mp_cnt);
    end
    step();
  endtask

  task automatic test_cfg_ignored();
    word_q_t w;
    int acc, cnt, cnt_s, lat;
    load_pattern(4'b1011);
    send_word(8'hF0, 1'b1, acc);
    step();
    cfg_pattern = 4'b1111;
    cfg_load = 1'b1;
    repeat (3) step();
    cfg_load = 1'b0;
    wait_report(cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL cfg_in_shift: got count=%0d required 0", cnt);
    end
    step();
    // Word and cfg_load together in IDLE: the word wins.
    cfg_pattern = 4'b1111;
    cfg_load = 1'b1;
    send_word(8'hF0, 1'b1, acc);
    cfg_load = 1'b0;
    wait_report(cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL cfg_collide: got count=%0d required 0", cnt);
    end
    step();
    w = '{8'hB0};
    run_frame(w, 0, cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 1) begin
      n_fail++;
      $display("FAIL old_pattern_kept: got count=%0d required 1", cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    word_q_t w;
    int acc, cnt, cnt_s, lat;
    send_word(8'hB0, 1'b1, acc);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || count_valid !== 1'b0 || bit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b cv=%b bv=%b required 0/0/0", busy, count_valid, bit_valid);
    end
    step();
    step();
    rst_n = 1'b1;
    cv_cnt = 0;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover: got ready=%b busy=%b required 1/0", in_ready, busy);
    end
    repeat (12) step();
    n_checks++;
    if (cv_cnt !== 0) begin
      n_fail++;
      $display("FAIL lost_frame_report: got %0d count_valid pulses required 0", cv_cnt);
    end
    // Pattern register returns to 0000 on reset.
    model_pat = '0;
    w = '{8'h00};
    run_frame(w, 0, cnt, cnt_s, lat);
    n_checks++;
    if (cnt !== 5 || cnt_s !== 3) begin
      n_fail++;
      $display("FAIL pattern_after_reset: got count=%0d sat_count=%0d required 5/3", cnt, cnt_s);
    end
    step();
  endtask

  task automatic test_random_frames();
    word_q_t w;
    bit exp_bits[$];
    int cnt, cnt_s, lat, raw, n_words;
    bit bad;
    for (int f = 0; f < 30; f++) begin
      load_pattern(PAT_W'($urandom));
      w.delete();
      exp_bits.delete();
      n_words = $urandom_range(4, 1);
      for (int i = 0; i < n_words; i++) w.push_back(DATA_W'($urandom));
      foreach (w[i]) for (int b = DATA_W - 1; b >= 0; b--) exp_bits.push_back(w[i][b]);
      raw = model_matches(w, model_pat);
      run_frame(w, 2, cnt, cnt_s, lat);
      n_checks++;
      if (cnt !== sat(raw, CNT_W) || cnt_s !== sat(raw, CNT_W_S) || count_valid_s !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_count frame %0d pat %b: got %0d/%0d cv_s=%b required %0d/%0d",
                 f, model_pat, cnt, cnt_s, count_valid_s, sat(raw, CNT_W), sat(raw, CNT_W_S));
      end
      n_checks++;
      if (mp_cnt !== raw || lat !== DATA_W + 2) begin
        n_fail++;
        $display("FAIL rand_pulses frame %0d: got pulses=%0d cycle=%0d required %0d/%0d",
                 f, mp_cnt, lat, raw, DATA_W + 2);
      end
      bad = (seen_bits.size() != exp_bits.size());
      if (!bad) foreach (exp_bits[k]) if (seen_bits[k] != exp_bits[k]) bad = 1'b1;
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand_serial frame %0d: got %0d bits (or wrong order) required %0d MSB-first",
                 f, seen_bits.size(), exp_bits.size());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overlap();
    test_back_to_back();
    test_frame_boundary();
    test_saturation();
    test_cfg_ignored();
    test_reset_mid_frame();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_stream_ctrl.md
# seq_det_stream_ctrl

Frame-level controller for serial pattern detection. Accepts parallel words over a valid/ready handshake, serialises them MSB-first into an embedded programmable Moore pattern detector, and counts matches across a frame of one or more words. When the last word of a frame has been shifted, it reports the saturating match count for one cycle, then clears the detector history. It sits between a word-oriented producer and any consumer of per-frame detection statistics.

## Interface
- DATA_W, 8, word width in bits
- PAT_W, 4, pattern length in bits (≥2, ≤DATA_W)
- CNT_W, 8, match counter width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset; async assert, sync release by upstream
- cfg_pattern  in  PAT_W  pattern to detect, MSB = first bit received
- cfg_load  in  1  latch cfg_pattern; honoured only in IDLE
- in_valid  in  1  word available
- in_data  in  DATA_W  word, shifted MSB-first
- in_last  in  1  word is last of frame; qualified by in_valid
- in_ready  out  1  controller accepts word this cycle
- bit_out  out  1  serial bit currently presented to detector
- bit_valid  out  1  bit_out is live
- match_pulse  out  1  detector Moore output: pattern completed on previous bit
- match_count  out  CNT_W  per-frame match count, valid with count_valid
- count_valid  out  1  one-cycle frame report strobe
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, SHIFT, FLUSH, REPORT. Reset → IDLE. All outputs are 0 at reset. The pattern register resets to 0. in_ready is 1 from the first cycle after reset deasserts.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load shift register with in_data, latch in_last, set bit_idx=DATA_W-1, go SHIFT.
  - Else if cfg_load: latch pattern and clear detector history.
- SHIFT:
  - bit_valid=1, bit_out=shreg MSB; each cycle shift left and decrement bit_idx.
  - At bit_idx==0 with last=0: in_ready=1. If a word is accepted, reload and stay in SHIFT with no bubble. Otherwise go IDLE; detector history is kept.
  - At bit_idx==0 with last=1: in_ready=0, go FLUSH.
- FLUSH: one cycle, so the match for the final bit is counted. Go REPORT.
- REPORT:
  - count_valid=1 and match_count=final count for exactly one cycle.
  - Count and detector history are cleared at the end of this cycle. Go IDLE.
- Detector:
  - Keeps a PAT_W-bit history and a fill counter, saturating at PAT_W.
  - Registered match_pulse=1 when fill==PAT_W and the history including the new bit equals the pattern.
  - Overlapping matches count, and matches may span word boundaries within a frame. No match is possible across a frame boundary.
- Counter:
  - Increments on match_pulse.
  - Saturates at 2^CNT_W-1; no wrap.
- cfg_load outside IDLE is ignored; no queuing.
- If in_valid and cfg_load arrive in IDLE together, the word wins and cfg_load is dropped.
- Reset asserted mid-frame: immediate return to IDLE with all state cleared. The partial frame is lost and no report is issued.

## Timing
- A word is accepted at edge 0. Its bits appear in cycles 1..DATA_W.
- match_pulse lags the completing bit by 1 cycle.
- For the last word: FLUSH in cycle DATA_W+1, REPORT in cycle DATA_W+2. in_ready is high again at cycle DATA_W+3.
- Back-to-back non-last words are gapless: DATA_W cycles per word.
- in_data and in_last are sampled only on the handshake edge.

## Structure
- Package seq_det_pkg holds:
  - the state enum (IDLE/SHIFT/FLUSH/REPORT);
  - the default widths;
  - a saturating-increment function.
- Sub-module seq_pattern_moore is the programmable detector: history, fill counter, pattern register and registered match. The controller owns the FSM, shift register and counter.

## Test plan
- Pattern 1011, frame = single word 0xB0 (last=1) → one match_pulse, report count=1 at cycle 10.
- Pattern 1011, single word 0x5B (01011011) → overlapping matches, count=2.
- Pattern 1011, words 0x01 then 0x60 (last on second) → 8+8 bit_valid cycles with no gap; cross-word match gives count=1.
- Two frames: 0x01 (last) then 0x60 (last) → both reports count=0; history is cleared at the frame boundary.
- CNT_W=2, pattern 0000, word 0x00 (last) → 5 raw matches, report count=3 (saturated).
- cfg_load pattern 1111 during SHIFT of 0xF0 → ignored, count under the old pattern. Then reset dropped mid-word → busy=0, no count_valid, in_ready=1 after release.
